// File: rtl/mem_op_pkg.sv
// Shared types and helpers for the queued memory operator: access size
// encodings, funct3 constants, FSM state type, queue entry layout and the
// load-extension / next-PC helpers.
package mem_op_pkg;

  localparam int MO_XLEN     = 32;
  localparam int MO_ID_WIDTH = 3;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DRAIN = 2'b10
  } mo_state_t;

  // One buffered load/store; the effective address is already resolved.
  typedef struct packed {
    logic [MO_ID_WIDTH-1:0] id;
    logic [MO_XLEN-1:0]     addr;
    logic [MO_XLEN-1:0]     data;
    logic                   rw;
    logic [2:0]             funct3;
    logic [MO_XLEN-1:0]     pc;
    logic                   cmp;
  } mo_entry_t;

  // Byte and halfword loads are sign-extended unless funct3[2] asks for
  // zero-extension; anything wider passes the raw data through.
  function automatic logic [MO_XLEN-1:0] extend_load(input logic [2:0]         f3,
                                                     input logic [MO_XLEN-1:0] raw);
    logic [MO_XLEN-1:0] v;
    v = raw;
    case (f3[1:0])
      SIZE_BYTE: v = {{(MO_XLEN-8){~f3[2] & raw[7]}}, raw[7:0]};
      SIZE_HALF: v = {{(MO_XLEN-16){~f3[2] & raw[15]}}, raw[15:0]};
      default:   v = raw;
    endcase
    return v;
  endfunction

  // Fall-through PC of a completed op, wrapping at 2^XLEN.
  function automatic logic [MO_XLEN-1:0] next_pc(input logic [MO_XLEN-1:0] pc,
                                                 input logic               cmp);
    return pc + (cmp ? MO_XLEN'(2) : MO_XLEN'(4));
  endfunction

endpackage

// File: rtl/mem_op_fifo.sv
// Program-order queue of pending memory ops. Clear wins over push/pop and
// everything is frozen while the enable is low.
module mem_op_fifo
  import mem_op_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_clear,
  input  mo_entry_t   i_wrEntry,
  output mo_entry_t   o_headEntry,
  output logic        o_full,
  output logic        o_empty,
  output logic [PW:0] o_count
);

  mo_entry_t          r_mem [DEPTH];
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [PW:0]        r_count;
  logic               w_doPush;
  logic               w_doPop;

  assign o_full      = (r_count == (PW+1)'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_headEntry = r_mem[r_head];
  assign w_doPush    = i_push & ~o_full;
  assign w_doPop     = i_pop & ~o_empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_en) begin
      if (i_clear) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_doPush) r_tail <= r_tail + 1'b1;
        if (w_doPop)  r_head <= r_head + 1'b1;
        if (w_doPush && !w_doPop)      r_count <= r_count + 1'b1;
        else if (!w_doPush && w_doPop) r_count <= r_count - 1'b1;
      end
    end
  end

  // Entry storage needs no reset: only slots between head and tail are ever read as valid.
  always_ff @(posedge i_clk) begin
    if (i_en && !i_clear && w_doPush) r_mem[r_tail] <= i_wrEntry;
  end

endmodule

// File: rtl/mem_operator_queued.sv
// Queued memory operator: buffers load/store ops in program order, issues
// them one at a time to the memory accessor with a hold-until-done request,
// and reports each completion as a single-cycle result pulse. A flush while
// an access is in flight lets that access finish silently.
module mem_operator_queued
  import mem_op_pkg::*;
#(
  parameter int XLEN     = MO_XLEN,
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = MO_ID_WIDTH,
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush_pipline,
  input  logic                have_ins,
  input  logic [ID_WIDTH-1:0] ins_id,
  input  logic [XLEN-1:0]     rs1_val,
  input  logic [XLEN-1:0]     rs2_val,
  input  logic [XLEN-1:0]     imm_val,
  input  logic                is_store,
  input  logic [2:0]          funct3,
  input  logic [XLEN-1:0]     request_PC,
  input  logic                is_compressed_ins,
  output logic                mo_available,
  output logic                mo_rdy,
  output logic [XLEN-1:0]     mo_res,
  output logic [ID_WIDTH-1:0] res_ins_id,
  output logic [XLEN-1:0]     completed_mo_resulting_PC,
  output logic                ma_have_mem_access_task,
  output logic [XLEN-1:0]     ma_mem_access_addr,
  output logic                ma_mem_access_rw,
  output logic [1:0]          ma_mem_access_size,
  output logic [XLEN-1:0]     ma_mem_access_data,
  input  logic                ma_mem_access_task_done,
  input  logic [XLEN-1:0]     ma_mem_access_data_out
);

  mo_state_t     r_state;
  mo_state_t     w_stateNext;
  mo_entry_t     r_cur;
  logic          r_req;
  logic          r_resValid;
  logic [XLEN-1:0]     r_res;
  logic [ID_WIDTH-1:0] r_resId;
  logic [XLEN-1:0]     r_resPc;

  mo_entry_t     w_newEntry;
  mo_entry_t     w_head;
  logic          w_full;
  logic          w_empty;
  logic [PW:0]   w_count;
  logic          w_push;
  logic          w_issue;
  logic          w_complete;

  assign w_newEntry.id     = ins_id;
  assign w_newEntry.addr   = rs1_val + imm_val;
  assign w_newEntry.data   = rs2_val;
  assign w_newEntry.rw     = is_store;
  assign w_newEntry.funct3 = funct3;
  assign w_newEntry.pc     = request_PC;
  assign w_newEntry.cmp    = is_compressed_ins;

  // Availability comes straight from the registered count, so a pop in the
  // same cycle never frees a slot for an enqueue until the next cycle.
  assign mo_available = (w_count < (PW+1)'(DEPTH));
  assign w_push       = have_ins & mo_available & ~w_full & ~flush_pipline;

  mem_op_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (clk_in),
    .i_rst_n     (rst_in),
    .i_en        (rdy_in),
    .i_push      (w_push),
    .i_pop       (w_complete),
    .i_clear     (flush_pipline),
    .i_wrEntry   (w_newEntry),
    .o_headEntry (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // State register; rdy_in low freezes the machine.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     r_state <= IDLE;
    else if (rdy_in) r_state <= w_stateNext;
  end

  // Next state plus the issue/complete strobes. A done coinciding with a
  // flush finishes the access but produces no result and pops nothing,
  // because the clear already discards the head.
  always_comb begin
    w_stateNext = r_state;
    w_issue     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!flush_pipline && !w_empty) begin
          w_stateNext = BUSY;
          w_issue     = 1'b1;
        end
      end
      BUSY: begin
        if (ma_mem_access_task_done) begin
          w_stateNext = IDLE;
          w_complete  = ~flush_pipline;
        end else if (flush_pipline) begin
          w_stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (ma_mem_access_task_done) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Captures the issued op, holds the request until done, and latches the extended result for a one-cycle pulse.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cur      <= '0;
      r_req      <= 1'b0;
      r_resValid <= 1'b0;
      r_res      <= '0;
      r_resId    <= '0;
      r_resPc    <= '0;
    end else if (rdy_in) begin
      r_resValid <= w_complete;
      if (w_issue) begin
        r_cur <= w_head;
        r_req <= 1'b1;
      end else if (r_state != IDLE && ma_mem_access_task_done) begin
        r_req <= 1'b0;
      end
      if (w_complete) begin
        r_res   <= r_cur.rw ? '0 : extend_load(r_cur.funct3, ma_mem_access_data_out);
        r_resId <= r_cur.id;
        r_resPc <= next_pc(r_cur.pc, r_cur.cmp);
      end
    end
  end

  assign ma_have_mem_access_task   = r_req;
  assign ma_mem_access_addr        = r_cur.addr;
  assign ma_mem_access_rw          = r_cur.rw;
  assign ma_mem_access_size        = r_cur.funct3[1:0];
  assign ma_mem_access_data        = r_cur.data;
  assign mo_rdy                    = r_resValid;
  assign mo_res                    = r_res;
  assign res_ins_id                = r_resId;
  assign completed_mo_resulting_PC = r_resPc;

endmodule

// File: tb/tb_mem_operator_queued.sv
// Bench for mem_operator_queued: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level queue model.
module tb_mem_operator_queued;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int IDW   = 3;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b0;
  logic            rdy_in = 1'b0;
  logic            flush_pipline = 1'b0;
  logic            have_ins = 1'b0;
  logic [IDW-1:0]  ins_id = '0;
  logic [XLEN-1:0] rs1_val = '0;
  logic [XLEN-1:0] rs2_val = '0;
  logic [XLEN-1:0] imm_val = '0;
  logic            is_store = 1'b0;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] request_PC = '0;
  logic            is_compressed_ins = 1'b0;
  logic            mo_available;
  logic            mo_rdy;
  logic [XLEN-1:0] mo_res;
  logic [IDW-1:0]  res_ins_id;
  logic [XLEN-1:0] completed_mo_resulting_PC;
  logic            ma_have_mem_access_task;
  logic [XLEN-1:0] ma_mem_access_addr;
  logic            ma_mem_access_rw;
  logic [1:0]      ma_mem_access_size;
  logic [XLEN-1:0] ma_mem_access_data;
  logic            ma_mem_access_task_done = 1'b0;
  logic [XLEN-1:0] ma_mem_access_data_out = '0;

  mem_operator_queued #(.XLEN(XLEN), .DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
    .clk_in                    (clk_in),
    .rst_in                    (rst_in),
    .rdy_in                    (rdy_in),
    .flush_pipline             (flush_pipline),
    .have_ins                  (have_ins),
    .ins_id                    (ins_id),
    .rs1_val                   (rs1_val),
    .rs2_val                   (rs2_val),
    .imm_val                   (imm_val),
    .is_store                  (is_store),
    .funct3                    (funct3),
    .request_PC                (request_PC),
    .is_compressed_ins         (is_compressed_ins),
    .mo_available              (mo_available),
    .mo_rdy                    (mo_rdy),
    .mo_res                    (mo_res),
    .res_ins_id                (res_ins_id),
    .completed_mo_resulting_PC (completed_mo_resulting_PC),
    .ma_have_mem_access_task   (ma_have_mem_access_task),
    .ma_mem_access_addr        (ma_mem_access_addr),
    .ma_mem_access_rw          (ma_mem_access_rw),
    .ma_mem_access_size        (ma_mem_access_size),
    .ma_mem_access_data        (ma_mem_access_data),
    .ma_mem_access_task_done   (ma_mem_access_task_done),
    .ma_mem_access_data_out    (ma_mem_access_data_out)
  );

  // Free-running 100 MHz clock.
  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
    logic            rw;
    logic            cmp;
    logic [2:0]      f3;
  } tbOp_t;

  int              checkCount = 0;
  int              errorCount = 0;

  tbOp_t           pendQ[$];
  tbOp_t           curOp;
  bit              inflight = 0;
  bit              killed = 0;
  bit              expRdy = 0;
  logic [XLEN-1:0] expRes = '0;
  logic [XLEN-1:0] expPc = '0;
  logic [IDW-1:0]  expId = '0;

  int              waitCnt = 0;
  int              lat = 1;
  bit              stall = 0;
  bit              randData = 0;
  logic [XLEN-1:0] memData = '0;

  int              rdySeen = 0;
  logic [XLEN-1:0] lastRes = '0;
  logic [XLEN-1:0] lastPc = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Load result from the extension rules, done with plain integer arithmetic.
  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] raw);
    longint v;
    case (f3[1:0])
      2'b00: begin
        v = raw % 256;
        if (!f3[2] && v >= 128) v = v - 256;
      end
      2'b01: begin
        v = raw % 65536;
        if (!f3[2] && v >= 32768) v = v - 65536;
      end
      default: v = raw;
    endcase
    return 32'(v);
  endfunction

  task automatic setOp(input logic [IDW-1:0] id, input logic [31:0] rs1, input logic [31:0] imm,
                       input logic [31:0] rs2, input logic st, input logic [2:0] f3,
                       input logic [31:0] pc, input logic cmp);
    ins_id = id; rs1_val = rs1; imm_val = imm; rs2_val = rs2;
    is_store = st; funct3 = f3; request_PC = pc; is_compressed_ins = cmp;
  endtask

  // One clock: memory responder drives done, edge happens, model advances, outputs are checked.
  task automatic tick();
    bit    willIssue;
    bit    doAcc;
    tbOp_t newOp;
    ma_mem_access_task_done = 1'b0;
    if (!ma_have_mem_access_task) waitCnt = lat;
    if (rdy_in && ma_have_mem_access_task && !stall) begin
      if (waitCnt <= 0) begin
        if (randData) memData = $urandom;
        ma_mem_access_task_done = 1'b1;
        ma_mem_access_data_out  = memData;
      end else begin
        waitCnt--;
      end
    end
    @(posedge clk_in);
    if (rdy_in) begin
      willIssue = !inflight && pendQ.size() > 0 && !flush_pipline;
      doAcc     = have_ins && !flush_pipline && pendQ.size() < DEPTH;
      expRdy    = 0;
      if (ma_mem_access_task_done && inflight) begin
        if (!killed && !flush_pipline) begin
          expRdy = 1;
          expId  = curOp.id;
          expRes = curOp.rw ? 32'h0 : refLoad(curOp.f3, ma_mem_access_data_out);
          expPc  = curOp.pc + (curOp.cmp ? 32'd2 : 32'd4);
          void'(pendQ.pop_front());
        end
        inflight = 0;
      end
      if (flush_pipline) begin
        pendQ.delete();
        if (inflight) killed = 1;
      end
      if (doAcc) begin
        newOp.id = ins_id; newOp.addr = rs1_val + imm_val; newOp.data = rs2_val;
        newOp.pc = request_PC; newOp.rw = is_store; newOp.cmp = is_compressed_ins; newOp.f3 = funct3;
        pendQ.push_back(newOp);
      end
      if (willIssue) begin
        curOp    = pendQ[0];
        inflight = 1;
        killed   = 0;
      end
    end
    #1;
    checkOutput("available", 32'(mo_available), 32'(pendQ.size() < DEPTH));
    checkOutput("request", 32'(ma_have_mem_access_task), 32'(inflight));
    if (inflight) begin
      checkOutput("maAddr", ma_mem_access_addr, curOp.addr);
      checkOutput("maRw", 32'(ma_mem_access_rw), 32'(curOp.rw));
      checkOutput("maSize", 32'(ma_mem_access_size), 32'(curOp.f3[1:0]));
      checkOutput("maData", ma_mem_access_data, curOp.data);
    end
    checkOutput("moRdy", 32'(mo_rdy), 32'(expRdy));
    if (expRdy) begin
      checkOutput("moRes", mo_res, expRes);
      checkOutput("resId", 32'(res_ins_id), 32'(expId));
      checkOutput("resPc", completed_mo_resulting_PC, expPc);
    end
    if (mo_rdy === 1'b1) begin
      rdySeen++;
      lastRes = mo_res;
      lastPc  = completed_mo_resulting_PC;
    end
  endtask

  task automatic applyStimulus(input int n);
    have_ins = 1'b0;
    repeat (n) tick();
  endtask

  // Holds have_ins until the model says the op was taken.
  task automatic enqueue();
    bit acc;
    have_ins = 1'b1;
    for (int i = 0; i < 60; i++) begin
      acc = rdy_in && !flush_pipline && pendQ.size() < DEPTH;
      tick();
      if (acc) return;
    end
    checkOutput("enqTimeout", 32'd0, 32'd1);
  endtask

  task automatic waitRdy(input int maxCycles);
    have_ins = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      tick();
      if (mo_rdy === 1'b1) return;
    end
    checkOutput("rdyTimeout", 32'd0, 32'd1);
  endtask

  task automatic randomOp();
    logic [2:0] f3;
    logic       st;
    st = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 4))
      0: f3 = 3'b000;
      1: f3 = 3'b001;
      2: f3 = 3'b010;
      3: f3 = st ? 3'b010 : 3'b100;
      default: f3 = st ? 3'b000 : 3'b101;
    endcase
    setOp(IDW'($urandom), $urandom, $urandom, $urandom, st, f3, $urandom, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("rstAvail", 32'(mo_available), 32'd1);
    checkOutput("rstReq", 32'(ma_have_mem_access_task), 32'd0);
    checkOutput("rstRdy", 32'(mo_rdy), 32'd0);
    checkOutput("rstRes", mo_res, 32'd0);
    rst_in = 1'b1;
    rdy_in = 1'b1;

    // lb with negative offset, sign-extended byte
    lat = 1; stall = 0; randData = 0; memData = 32'h0000_0080;
    setOp(3'd1, 32'h1000, 32'hFFFF_FFFF, 32'h0, 1'b0, 3'b000, 32'h100, 1'b0);
    enqueue();
    have_ins = 1'b0;
    checkOutput("issueLat0", 32'(ma_have_mem_access_task), 32'd0);
    applyStimulus(1);
    checkOutput("issueLat1", 32'(ma_have_mem_access_task), 32'd1);
    checkOutput("lbAddr", ma_mem_access_addr, 32'h0000_0FFF);
    checkOutput("lbSize", 32'(ma_mem_access_size), 32'd0);
    waitRdy(20);
    checkOutput("lbRes", lastRes, 32'hFFFF_FF80);
    checkOutput("lbPc", lastPc, 32'h104);
    applyStimulus(1);
    checkOutput("pulseWidth", 32'(mo_rdy), 32'd0);

    // compressed sh
    setOp(3'd2, 32'h20, 32'h4, 32'hBEEF, 1'b1, 3'b001, 32'h200, 1'b1);
    enqueue();
    applyStimulus(1);
    checkOutput("shAddr", ma_mem_access_addr, 32'h24);
    checkOutput("shRw", 32'(ma_mem_access_rw), 32'd1);
    checkOutput("shData", ma_mem_access_data, 32'hBEEF);
    waitRdy(20);
    checkOutput("shRes", lastRes, 32'd0);
    checkOutput("shPc", lastPc, 32'h202);

    // fill the queue while memory stalls; the fifth op must wait for space
    stall = 1; randData = 1;
    for (int i = 0; i < 4; i++) begin
      setOp(IDW'(i), 32'h3000 + 32'(i * 16), 32'h0, 32'(i), 1'b0, 3'b010, 32'h400 + 32'(i * 4), 1'b0);
      enqueue();
    end
    checkOutput("fullAvail", 32'(mo_available), 32'd0);
    setOp(3'd4, 32'h3040, 32'h0, 32'h4, 1'b0, 3'b010, 32'h410, 1'b0);
    have_ins = 1'b1;
    repeat (3) tick();
    stall = 0;
    rdySeen = 0;
    enqueue();
    applyStimulus(40);
    checkOutput("fiveDone", 32'(rdySeen), 32'd5);

    // flush in BUSY with three queued, then a post-flush lw during drain
    stall = 1; randData = 0; memData = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      setOp(IDW'(i + 1), 32'h5000, 32'(i * 4), 32'h0, 1'b0, 3'b000, 32'h600, 1'b0);
      enqueue();
    end
    applyStimulus(2);
    rdySeen = 0;
    flush_pipline = 1'b1;
    tick();
    flush_pipline = 1'b0;
    setOp(3'd6, 32'h6000, 32'h8, 32'h0, 1'b0, 3'b010, 32'h700, 1'b0);
    enqueue();
    applyStimulus(3);
    checkOutput("drainHold", 32'(ma_have_mem_access_task), 32'd1);
    checkOutput("drainAddr", ma_mem_access_addr, 32'h5000);
    stall = 0;
    applyStimulus(20);
    checkOutput("flushPulses", 32'(rdySeen), 32'd1);
    checkOutput("postFlushLw", lastRes, 32'h1234_5678);

    // lhu with a rdy_in freeze mid-BUSY
    stall = 1; memData = 32'hFFFF_8001;
    setOp(3'd3, 32'h7000, 32'h2, 32'h0, 1'b0, 3'b101, 32'h800, 1'b0);
    enqueue();
    applyStimulus(2);
    rdy_in = 1'b0;
    applyStimulus(4);
    rdy_in = 1'b1;
    stall = 0;
    waitRdy(20);
    checkOutput("lhuRes", lastRes, 32'h0000_8001);

    // asynchronous reset while an access is outstanding
    stall = 1;
    setOp(3'd5, 32'h9000, 32'h0, 32'hAA, 1'b1, 3'b010, 32'h900, 1'b0);
    enqueue();
    applyStimulus(2);
    #2 rst_in = 1'b0;
    #1;
    checkOutput("arstAvail", 32'(mo_available), 32'd1);
    checkOutput("arstReq", 32'(ma_have_mem_access_task), 32'd0);
    checkOutput("arstAddr", ma_mem_access_addr, 32'd0);
    checkOutput("arstRw", 32'(ma_mem_access_rw), 32'd0);
    checkOutput("arstData", ma_mem_access_data, 32'd0);
    checkOutput("arstRdy", 32'(mo_rdy), 32'd0);
    checkOutput("arstRes", mo_res, 32'd0);
    checkOutput("arstId", 32'(res_ins_id), 32'd0);
    checkOutput("arstPc", completed_mo_resulting_PC, 32'd0);
    pendQ.delete();
    inflight = 0; killed = 0; expRdy = 0;
    have_ins = 1'b0;
    stall = 0;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;

    // randomized traffic with flushes, freezes and varying memory latency
    randData = 1;
    for (int c = 0; c < 400; c++) begin
      rdy_in        = ($urandom_range(0, 9) != 0);
      flush_pipline = rdy_in && ($urandom_range(0, 29) == 0);
      lat           = $urandom_range(0, 3);
      have_ins      = 1'($urandom_range(0, 1));
      randomOp();
      tick();
    end
    rdy_in = 1'b1;
    flush_pipline = 1'b0;
    applyStimulus(40);
    checkOutput("finalEmpty", 32'(pendQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
